booth4_iter_mult_ctrl: RTL

Iterative radix-4 Booth signed 16x16 multiplier controller with a sequenced datapath.
It applies one Booth digit per cycle (8 digits) and shares a single digit decoder and a single 32-bit adder across all steps.
It is the area-reduced alternative to the fully parallel 8-partial-product generator plus Wallace tree, for low-throughput users.
Operands arrive and the product leaves through valid/ready handshakes.

---
 rtl/booth4_iter_mult_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/booth4_iter_mult_ctrl.sv
// Iterative radix-4 Booth signed NxN multiplier controller.
// One Booth digit is applied per clock through a single shared digit decoder
// and a single 2N-bit adder, so a product takes N/2 CALC cycles.
//
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   in_valid/in_ready  : operand handshake, A_NUM (multiplicand), B_NUM (multiplier)
//   abort              : synchronous cancel, returns to IDLE and clears the accumulator
//   out_valid/out_ready: product handshake, PRODUCT (2N-bit two's complement)
//   busy               : high while digits are being applied
//   digit_idx          : digit being applied (debug), 0 outside CALC
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | applying Booth digit cnt_q, busy=1
// DONE  | product held on PRODUCT, out_valid=1 until out_ready
module booth4_iter_mult_ctrl #(
    parameter int N     = 16,
    parameter int CNT_W = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A_NUM,
    input  logic [N-1:0]     B_NUM,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   PRODUCT,
    output logic             busy,
    output logic [CNT_W-1:0] digit_idx
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q;
    logic [N:0]       b_q;
    logic [2*N-1:0]   acc_q;
    logic [2*N-1:0]   prod_q;
    logic [CNT_W-1:0] cnt_q;

    logic             last_step;
    logic [2:0]       digit;
    logic [N+1:0]     a1, a2, pp;
    logic [2*N-1:0]   pp_ext, pp_shift, acc_sum;

    assign last_step = (cnt_q == CNT_W'(N/2 - 1));

    // b_q carries the implicit zero below the LSB, so digit cnt covers bits 2cnt+2..2cnt.
    assign digit = b_q[{cnt_q, 1'b0} +: 3];

    // +A and +2A at N+2 bits; wide enough that -2 * (-2^(N-1)) still fits.
    assign a1 = {{2{a_q[N-1]}}, a_q};
    assign a2 = {a_q[N-1], a_q, 1'b0};

    always_comb begin
        pp = '0;
        case (digit)
            3'b001, 3'b010: pp = a1;
            3'b011:         pp = a2;
            3'b100:         pp = ~a2 + (N+2)'(1);
            3'b101, 3'b110: pp = ~a1 + (N+2)'(1);
            default:        pp = '0;
        endcase
    end

    assign pp_ext   = {{(N-2){pp[N+1]}}, pp};
    assign pp_shift = pp_ext << {cnt_q, 1'b0};
    assign acc_sum  = acc_q + pp_shift;

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides both handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_CALC;
            S_CALC:  if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Output decode, from state only
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_CALC);
        out_valid = (state_q == S_DONE);
        digit_idx = (state_q == S_CALC) ? cnt_q : '0;
    end

    assign PRODUCT = prod_q;

    // Datapath
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else if (abort) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= A_NUM;
                        b_q   <= {B_NUM, 1'b0};
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_sum;
                    cnt_q <= last_step ? '0 : cnt_q + CNT_W'(1);
                    if (last_step) prod_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule
